// File: rtl/router_merge_arbiter.sv
// router_merge_arbiter
//   Round-robin merge of NUM_IN upstream FWFT buffers into one internal FWFT
//   output FIFO. The downstream stage drains it with the same ren/empty handshake.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   din             upstream heads, source i at [i*PACKET_WIDTH +: PACKET_WIDTH]
//   empty_in        upstream empty flags (1 = no packet)
//   ren_out         one-hot-or-zero pop strobe to the upstream buffers
//   ren_in          downstream pop request
//   dout            output FIFO head, valid when empty_out = 0
//   empty_out       output FIFO empty
//   full_out        output FIFO holds BUFFER_DEPTH entries
//   pkt_count       (ROUTER_MERGE_ARB_STATS_EN only) saturating grant counter
//
// Optional feature macro: ROUTER_MERGE_ARB_STATS_EN

module router_merge_arbiter #(
    parameter int unsigned PACKET_WIDTH = 30,
    parameter int unsigned NUM_IN       = 3,
    parameter int unsigned BUFFER_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_IN*PACKET_WIDTH-1:0] din,
    input  logic [NUM_IN-1:0]              empty_in,
    output logic [NUM_IN-1:0]              ren_out,
    input  logic                           ren_in,
    output logic [PACKET_WIDTH-1:0]        dout,
    output logic                           empty_out,
    output logic                           full_out
`ifdef ROUTER_MERGE_ARB_STATS_EN
    ,
    output logic [15:0]                    pkt_count
`endif
);

    localparam int unsigned PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned ADDR_W = $clog2(BUFFER_DEPTH);
    localparam int unsigned CNT_W  = $clog2(BUFFER_DEPTH + 1);

    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        rr_ptr_nxt;
    logic [NUM_IN-1:0]       grant;
    logic                    grant_any;
    logic [PTR_W-1:0]        grant_idx;
    int unsigned             scan_idx;
    logic                    rst_hold;
    logic                    space_ok;
    logic                    wr_en;
    logic                    rd_en;
    logic [PACKET_WIDTH-1:0] wr_data;

    logic [CNT_W-1:0]        count;
    logic [ADDR_W-1:0]       wptr;
    logic [ADDR_W-1:0]       rptr;
    logic [PACKET_WIDTH-1:0] mem [BUFFER_DEPTH];

    // Free-slot check uses the registered count only: no ren_in -> ren_out path.
    assign space_ok = (count != CNT_W'(BUFFER_DEPTH));

    // Round-robin scan from rr_ptr; grants are suppressed during reset and
    // for the single cycle that follows it (rst_hold).
    always_comb begin
        grant      = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        scan_idx   = 0;
        rr_ptr_nxt = rr_ptr;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            scan_idx = 32'(rr_ptr) + k;
            if (scan_idx >= NUM_IN) begin
                scan_idx = scan_idx - NUM_IN;
            end
            if (!grant_any && !empty_in[PTR_W'(scan_idx)] && space_ok && !reset && !rst_hold) begin
                grant[PTR_W'(scan_idx)] = 1'b1;
                grant_any               = 1'b1;
                grant_idx               = PTR_W'(scan_idx);
            end
        end
        if (grant_any) begin
            rr_ptr_nxt = (grant_idx == PTR_W'(NUM_IN - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    assign ren_out   = grant;
    assign wr_en     = grant_any;
    assign wr_data   = din[32'(grant_idx)*PACKET_WIDTH +: PACKET_WIDTH];
    assign rd_en     = ren_in && (count != '0);

    assign dout      = mem[rptr];
    assign empty_out = (count == '0);
    assign full_out  = (count == CNT_W'(BUFFER_DEPTH));

    // Arbiter pointer and output FIFO state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            rst_hold <= 1'b1;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else begin
            rst_hold <= 1'b0;
            rr_ptr   <= rr_ptr_nxt;
            if (wr_en) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + ADDR_W'(1);
            end
            if (rd_en) begin
                rptr <= rptr + ADDR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ROUTER_MERGE_ARB_STATS_EN
    logic [15:0] pkt_cnt_q;

    // Saturating count of grant cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else if (wr_en && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_router_merge_arbiter.sv
// tb_router_merge_arbiter
//   Directed bench for router_merge_arbiter (PACKET_WIDTH=30, NUM_IN=3,
//   BUFFER_DEPTH=4). Inputs change 1 time unit after the rising edge; outputs
//   are sampled 1 time unit later, well before the next edge.

module tb_router_merge_arbiter;

    localparam int unsigned PW = 30;
    localparam int unsigned NI = 3;
    localparam int unsigned BD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NI*PW-1:0]  din;
    logic [NI-1:0]     empty_in;
    logic [NI-1:0]     ren_out;
    logic              ren_in;
    logic [PW-1:0]     dout;
    logic              empty_out;
    logic              full_out;
`ifdef ROUTER_MERGE_ARB_STATS_EN
    logic [15:0]       pkt_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    router_merge_arbiter #(
        .PACKET_WIDTH (PW),
        .NUM_IN       (NI),
        .BUFFER_DEPTH (BD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .empty_in  (empty_in),
        .ren_out   (ren_out),
        .ren_in    (ren_in),
        .dout      (dout),
        .empty_out (empty_out),
        .full_out  (full_out)
`ifdef ROUTER_MERGE_ARB_STATS_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles, then the post-reset hold cycle; ends with the
    // arbiter ready to grant from source 0 and the FIFO empty.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_ren_during", 32'(ren_out), 32'h0);
        step();
        check("rst_ren_c1", 32'(ren_out), 32'h0);
        check("rst_empty_c1", 32'(empty_out), 32'h1);
        check("rst_full_c1", 32'(full_out), 32'h0);
        step();
        reset = 1'b0;
        #1;
        check("rst_ren_after", 32'(ren_out), 32'h0);
        check("rst_empty_after", 32'(empty_out), 32'h1);
        check("rst_full_after", 32'(full_out), 32'h0);
        check("rst_dout_after", 32'(dout), 32'h0);
        step();
    endtask

    logic [NI-1:0] exp_rr   [4];
    logic [PW-1:0] exp_head [4];

    initial begin
        reset    = 1'b1;
        ren_in   = 1'b0;
        empty_in = '0;
        din      = {30'hC, 30'hB, 30'hA};
        exp_rr   = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_head = '{30'hA, 30'hB, 30'hC, 30'hA};

        // Reset with all sources non-empty, then first grant.
        do_reset();
        #1;
        check("first_grant", 32'(ren_out), 32'h1);
        check("first_empty", 32'(empty_out), 32'h1);

        // Round robin with a draining downstream.
        ren_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ren", 32'(ren_out), 32'(exp_rr[i]));
            step();
            check("rr_dout", 32'(dout), 32'(exp_head[i]));
            check("rr_empty", 32'(empty_out), 32'h0);
        end

        // Skip empty sources.
        empty_in = 3'b111;
        do_reset();
        empty_in = 3'b011;
        #1;
        check("skip_src2", 32'(ren_out), 32'h4);
        step();
        check("skip_dout_c", 32'(dout), 32'hC);
        empty_in = 3'b010;
        #1;
        check("skip_src0_first", 32'(ren_out), 32'h1);
        step();
        check("skip_dout_a", 32'(dout), 32'hA);
        #1;
        check("skip_then_src2", 32'(ren_out), 32'h4);

        // Back-pressure: exactly four grants then full.
        empty_in = 3'b000;
        ren_in   = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_grant", 32'(ren_out), 32'(exp_rr[i]));
            check("bp_not_full", 32'(full_out), 32'h0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check("bp_full", 32'(full_out), 32'h1);
            check("bp_no_grant", 32'(ren_out), 32'h0);
            step();
        end
        check("bp_dout_head", 32'(dout), 32'hA);
        ren_in = 1'b1;
        #1;
        check("bp_no_comb_path", 32'(ren_out), 32'h0);
        step();
        ren_in = 1'b0;
        #1;
        check("bp_slot_freed", 32'(full_out), 32'h0);
        check("bp_grant_resume", 32'(ren_out), 32'h2);
        check("bp_dout_next", 32'(dout), 32'hB);
        step();
        check("bp_full_again", 32'(full_out), 32'h1);

        // Simultaneous read/write at count 2, then underflow protection.
        do_reset();
        step();
        step();
        ren_in = 1'b1;
        #1;
        check("rw_dout_before", 32'(dout), 32'hA);
        check("rw_grant", 32'(ren_out), 32'h4);
        step();
        empty_in = 3'b111;
        check("rw_dout_after", 32'(dout), 32'hB);
        check("rw_not_full", 32'(full_out), 32'h0);
        step();
        check("rw_dout_c", 32'(dout), 32'hC);
        check("rw_still_data", 32'(empty_out), 32'h0);
        step();
        check("rw_drained", 32'(empty_out), 32'h1);
        step();
        check("under_empty", 32'(empty_out), 32'h1);
        check("under_full", 32'(full_out), 32'h0);
        ren_in   = 1'b0;
        empty_in = 3'b110;
        #1;
        check("under_grant0", 32'(ren_out), 32'h1);
        step();
        empty_in = 3'b111;
        check("under_one_entry", 32'(empty_out), 32'h0);
        check("under_dout", 32'(dout), 32'hA);
        ren_in = 1'b1;
        step();
        check("under_empty_again", 32'(empty_out), 32'h1);

        // Reset mid-operation discards held packets.
        ren_in   = 1'b0;
        empty_in = 3'b000;
        step();
        step();
        do_reset();

`ifdef ROUTER_MERGE_ARB_STATS_EN
        ren_in = 1'b1;
        repeat (10) step();
        check("stats_10", 32'(pkt_count), 32'd10);
        repeat (65524) step();
        check("stats_fffe", 32'(pkt_count), 32'hFFFE);
        repeat (3) step();
        check("stats_sat", 32'(pkt_count), 32'hFFFF);
        step();
        check("stats_hold", 32'(pkt_count), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
